// File: rtl/pin_entry.sv
// pin_entry: four-digit BCD PIN entry front end driven by four raw buttons.
// Each button is debounced with a 4-sample shift register and converted to
// a single-cycle press pulse. A three-state machine (ENTRY, DONE, LOCKED)
// builds the PIN, hands it to a downstream verifier with a validPin pulse,
// and reacts to the verifier's success/fail answer.
//
// Build option: define PIN_LOCKOUT_EN to compile in the consecutive-failure
// counter and the timed LOCKED state. Without it, fail_event simply returns
// the block to ENTRY and locked is tied low.
module pin_entry #(
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int MAX_FAILS      = 3
) (
  input  logic        clk_500Hz,
  input  logic        rst_n,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnC,
  input  logic        btnL,
  input  logic        success_event,
  input  logic        fail_event,
  output logic [15:0] userPin,
  output logic        validPin,
  output logic [3:0]  cur_digit,
  output logic [1:0]  digit_idx,
  output logic        locked
);

  // Reject configurations that make the lockout arithmetic meaningless.
  generate
    if (LOCKOUT_CYCLES < 1 || MAX_FAILS < 1) begin : g_cfg_check
      $error("pin_entry: LOCKOUT_CYCLES and MAX_FAILS must both be >= 1");
    end
  endgenerate

  // Button bit positions inside the packed raw/press vectors.
  localparam int B_D = 0;
  localparam int B_U = 1;
  localparam int B_C = 2;
  localparam int B_L = 3;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    DONE   = 2'd1
`ifdef PIN_LOCKOUT_EN
    ,
    LOCKED = 2'd2
`endif
  } state_t;

  logic [3:0] btn_raw;
  logic [3:0] press;

  assign btn_raw = {btnL, btnC, btnU, btnD};

  // --------------------------------------------------------------------------
  // Debounce and edge detection, one identical slice per button.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      logic [3:0] shift_reg;
      logic       clean_reg;
      logic       clean_d_reg;

      // Shift in raw samples; the clean level only moves on 4 agreeing samples.
      always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
          shift_reg   <= 4'b0000;
          clean_reg   <= 1'b0;
          clean_d_reg <= 1'b0;
        end else begin
          shift_reg <= {shift_reg[2:0], btn_raw[gi]};
          if (shift_reg == 4'b1111) begin
            clean_reg <= 1'b1;
          end else if (shift_reg == 4'b0000) begin
            clean_reg <= 1'b0;
          end
          clean_d_reg <= clean_reg;
        end
      end

      // Rising edge of the clean level gives one press pulse per push.
      assign press[gi] = clean_reg & ~clean_d_reg;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and datapath registers.
  // --------------------------------------------------------------------------
  state_t      state_reg,     state_next;
  logic [15:0] slots_reg,     slots_next;
  logic [15:0] user_pin_reg,  user_pin_next;
  logic        valid_reg,     valid_next;
  logic [3:0]  cur_digit_reg, cur_digit_next;
  logic [1:0]  digit_idx_reg, digit_idx_next;

`ifdef PIN_LOCKOUT_EN
  localparam int FAIL_W = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [FAIL_W-1:0] MAX_F     = FAIL_W'(MAX_FAILS);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

  logic [FAIL_W-1:0] fail_cnt_reg, fail_cnt_next;
  logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic [FAIL_W-1:0] fail_cnt_inc;

  assign fail_cnt_inc = fail_cnt_reg + FAIL_W'(1);
`endif

  // Register every piece of state; reset abandons any partial entry.
  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ENTRY;
      slots_reg     <= 16'h0000;
      user_pin_reg  <= 16'h0000;
      valid_reg     <= 1'b0;
      cur_digit_reg <= 4'd0;
      digit_idx_reg <= 2'd0;
`ifdef PIN_LOCKOUT_EN
      fail_cnt_reg  <= '0;
      lock_cnt_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      slots_reg     <= slots_next;
      user_pin_reg  <= user_pin_next;
      valid_reg     <= valid_next;
      cur_digit_reg <= cur_digit_next;
      digit_idx_reg <= digit_idx_next;
`ifdef PIN_LOCKOUT_EN
      fail_cnt_reg  <= fail_cnt_next;
      lock_cnt_reg  <= lock_cnt_next;
`endif
    end
  end

  // Next-state and datapath: at most one button action is taken per cycle.
  always_comb begin
    state_next     = state_reg;
    slots_next     = slots_reg;
    user_pin_next  = user_pin_reg;
    valid_next     = 1'b0;
    cur_digit_next = cur_digit_reg;
    digit_idx_next = digit_idx_reg;
`ifdef PIN_LOCKOUT_EN
    fail_cnt_next  = fail_cnt_reg;
    lock_cnt_next  = lock_cnt_reg;
`endif

    case (state_reg)
      ENTRY: begin
        if (press[B_L]) begin
          slots_next     = 16'h0000;
          cur_digit_next = 4'd0;
          digit_idx_next = 2'd0;
        end else if (press[B_C]) begin
          // Slot 0 (first digit) lives in the top nibble, so index with 3-idx.
          slots_next[{~digit_idx_reg, 2'b00} +: 4] = cur_digit_reg;
          cur_digit_next = 4'd0;
          digit_idx_next = digit_idx_reg + 2'd1;
          if (digit_idx_reg == 2'd3) begin
            user_pin_next = {slots_reg[15:4], cur_digit_reg};
            valid_next    = 1'b1;
            state_next    = DONE;
          end
        end else if (press[B_U]) begin
          cur_digit_next = (cur_digit_reg >= 4'd9) ? 4'd0 : cur_digit_reg + 4'd1;
        end else if (press[B_D]) begin
          cur_digit_next = (cur_digit_reg == 4'd0) ? 4'd9 : cur_digit_reg - 4'd1;
        end
      end

      DONE: begin
        // Every exit from DONE starts the next entry from a clean slate;
        // userPin keeps the last submitted value.
        if (success_event) begin
          slots_next     = 16'h0000;
          cur_digit_next = 4'd0;
          digit_idx_next = 2'd0;
          state_next     = ENTRY;
`ifdef PIN_LOCKOUT_EN
          fail_cnt_next  = '0;
`endif
        end else if (fail_event) begin
          slots_next     = 16'h0000;
          cur_digit_next = 4'd0;
          digit_idx_next = 2'd0;
          state_next     = ENTRY;
`ifdef PIN_LOCKOUT_EN
          fail_cnt_next  = fail_cnt_inc;
          if (fail_cnt_inc >= MAX_F) begin
            state_next    = LOCKED;
            lock_cnt_next = LOCK_LOAD;
          end
`endif
        end else if (press[B_L]) begin
          slots_next     = 16'h0000;
          cur_digit_next = 4'd0;
          digit_idx_next = 2'd0;
          state_next     = ENTRY;
        end
      end

`ifdef PIN_LOCKOUT_EN
      LOCKED: begin
        // Inputs are deaf here; only the countdown can release the block.
        if (lock_cnt_reg == '0) begin
          fail_cnt_next = '0;
          state_next    = ENTRY;
        end else begin
          lock_cnt_next = lock_cnt_reg - LOCK_W'(1);
        end
      end
`endif

      default: begin
        state_next = ENTRY;
      end
    endcase
  end

  assign userPin   = user_pin_reg;
  assign validPin  = valid_reg;
  assign cur_digit = cur_digit_reg;
  assign digit_idx = digit_idx_reg;

`ifdef PIN_LOCKOUT_EN
  assign locked = (state_reg == LOCKED);
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pin_entry.sv
// tb_pin_entry: directed bench for pin_entry. Expected PINs are queued when a
// complete entry is driven and popped when validPin is seen; every other
// expectation is a constant derived from the button sequence applied.
module tb_pin_entry;

  logic        clk_500Hz = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnU = 1'b0;
  logic        btnD = 1'b0;
  logic        btnC = 1'b0;
  logic        btnL = 1'b0;
  logic        success_event = 1'b0;
  logic        fail_event = 1'b0;
  logic [15:0] userPin;
  logic        validPin;
  logic [3:0]  cur_digit;
  logic [1:0]  digit_idx;
  logic        locked;

  int checks = 0;
  int errors = 0;
  int vp_count = 0;
  logic [15:0] exp_q[$];

  always #5 clk_500Hz = ~clk_500Hz;

  pin_entry dut (
    .clk_500Hz     (clk_500Hz),
    .rst_n         (rst_n),
    .btnU          (btnU),
    .btnD          (btnD),
    .btnC          (btnC),
    .btnL          (btnL),
    .success_event (success_event),
    .fail_event    (fail_event),
    .userPin       (userPin),
    .validPin      (validPin),
    .cur_digit     (cur_digit),
    .digit_idx     (digit_idx),
    .locked        (locked)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_500Hz);
    #1;
  endtask

  // m = {btnL, btnC, btnU, btnD}
  task automatic press(input logic [3:0] m, input int hold);
    {btnL, btnC, btnU, btnD} = m;
    repeat (hold) tick();
    {btnL, btnC, btnU, btnD} = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic enter_pin(input logic [15:0] pin);
    logic [3:0] d;
    for (int i = 3; i >= 0; i--) begin
      d = pin[i*4 +: 4];
      for (int k = 0; k < int'(d); k++) press(4'b0010, 8);
      if (i == 0) exp_q.push_back(pin);
      press(4'b0100, 8);
    end
  endtask

  task automatic pulse_event(input bit is_fail);
    if (is_fail) fail_event = 1'b1; else success_event = 1'b1;
    tick();
    fail_event = 1'b0;
    success_event = 1'b0;
  endtask

  // Scoreboard side: every validPin pulse must match the oldest queued PIN.
  always @(negedge clk_500Hz) begin
    if (validPin) begin
      vp_count++;
      $display("txn validPin userPin=%h", userPin);
      if (exp_q.size() == 0) chk("unexpected_validPin", {15'b0, validPin}, 16'h0000);
      else chk("userPin_scoreboard", userPin, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int vp_before;

    // Reset state
    repeat (3) tick();
    chk("rst_userPin", userPin, 16'h0000);
    chk("rst_validPin", {15'b0, validPin}, 16'h0000);
    chk("rst_cur_digit", {12'b0, cur_digit}, 16'h0000);
    chk("rst_digit_idx", {14'b0, digit_idx}, 16'h0000);
    chk("rst_locked", {15'b0, locked}, 16'h0000);
    rst_n = 1'b1;
    repeat (2) tick();

    // Entry U x3, C, U x9, C, D, C, C -> 3990
    repeat (3) press(4'b0010, 8);
    chk("entry_cur3", {12'b0, cur_digit}, 16'h0003);
    press(4'b0100, 8);
    chk("entry_idx1", {14'b0, digit_idx}, 16'h0001);
    chk("entry_cur_reset", {12'b0, cur_digit}, 16'h0000);
    repeat (9) press(4'b0010, 8);
    chk("entry_cur9", {12'b0, cur_digit}, 16'h0009);
    press(4'b0100, 8);
    press(4'b0001, 8);
    chk("entry_dwrap9", {12'b0, cur_digit}, 16'h0009);
    press(4'b0100, 8);
    chk("entry_idx3", {14'b0, digit_idx}, 16'h0003);
    exp_q.push_back(16'h3990);
    press(4'b0100, 8);
    chk("entry_idx_back0", {14'b0, digit_idx}, 16'h0000);
    chk("entry_userPin", userPin, 16'h3990);
    chk("entry_one_pulse", 16'(vp_count), 16'd1);

    // DONE ignores U and C
    press(4'b0010, 8);
    chk("done_ignore_U", {12'b0, cur_digit}, 16'h0000);
    press(4'b0100, 8);
    chk("done_ignore_C", 16'(vp_count), 16'd1);
    chk("done_userPin_stable", userPin, 16'h3990);

    // success returns to ENTRY, userPin kept
    pulse_event(1'b0);
    press(4'b0010, 8);
    chk("after_success_U", {12'b0, cur_digit}, 16'h0001);
    chk("after_success_userPin", userPin, 16'h3990);

    // Priority: L beats U, C beats U
    press(4'b1010, 8);
    chk("prio_L_over_U_cur", {12'b0, cur_digit}, 16'h0000);
    press(4'b0010, 8);
    press(4'b0110, 8);
    chk("prio_C_over_U_idx", {14'b0, digit_idx}, 16'h0001);
    chk("prio_C_over_U_cur", {12'b0, cur_digit}, 16'h0000);
    press(4'b1000, 8);

    // Wrap
    press(4'b0001, 8);
    chk("wrap_down_0_to_9", {12'b0, cur_digit}, 16'h0009);
    press(4'b0010, 8);
    chk("wrap_up_9_to_0", {12'b0, cur_digit}, 16'h0000);

    // Clear after two digits
    vp_before = vp_count;
    press(4'b0010, 8);
    press(4'b0100, 8);
    press(4'b0010, 8);
    press(4'b0010, 8);
    press(4'b0100, 8);
    chk("clear_pre_idx2", {14'b0, digit_idx}, 16'h0002);
    press(4'b0010, 8);
    press(4'b1000, 8);
    chk("clear_idx", {14'b0, digit_idx}, 16'h0000);
    chk("clear_cur", {12'b0, cur_digit}, 16'h0000);
    chk("clear_no_valid", 16'(vp_count), 16'(vp_before));

    // Events in ENTRY are ignored
    press(4'b0010, 8);
    pulse_event(1'b1);
    pulse_event(1'b0);
    chk("entry_events_cur", {12'b0, cur_digit}, 16'h0001);
    chk("entry_events_locked", {15'b0, locked}, 16'h0000);
    press(4'b1000, 8);

    // Debounce: 3-cycle glitch ignored, long hold counts once
    btnU = 1'b1;
    repeat (3) tick();
    btnU = 1'b0;
    repeat (10) tick();
    chk("glitch_ignored", {12'b0, cur_digit}, 16'h0000);
    press(4'b0010, 40);
    chk("held_one_increment", {12'b0, cur_digit}, 16'h0001);
    press(4'b1000, 8);

    // btnL in DONE returns to ENTRY
    enter_pin(16'h1200);
    press(4'b1000, 8);
    press(4'b0010, 8);
    chk("done_L_to_entry", {12'b0, cur_digit}, 16'h0001);
    press(4'b1000, 8);

`ifdef PIN_LOCKOUT_EN
    // Three failures lock for exactly LOCKOUT_CYCLES
    for (int k = 0; k < 3; k++) begin
      enter_pin(16'h0120);
      pulse_event(1'b1);
      if (k < 2) chk("fail_not_locked_yet", {15'b0, locked}, 16'h0000);
    end
    vp_before = vp_count;
    n = 0;
    while (locked && n < 6000) begin
      btnC = ((n % 40) < 20) && (n < 4000);
      n++;
      tick();
    end
    btnC = 1'b0;
    chk("lock_duration", 16'(n), 16'd5000);
    chk("lock_btnC_idx", {14'b0, digit_idx}, 16'h0000);
    chk("lock_btnC_cur", {12'b0, cur_digit}, 16'h0000);
    chk("lock_btnC_novalid", 16'(vp_count), 16'(vp_before));
    enter_pin(16'h0007);
    pulse_event(1'b1);
    chk("fail_cnt_zeroed", {15'b0, locked}, 16'h0000);
    pulse_event(1'b0);
`else
    // Without lockout, fail_event just returns to ENTRY
    for (int k = 0; k < 3; k++) begin
      enter_pin(16'h0120);
      pulse_event(1'b1);
      chk("fail_no_lock", {15'b0, locked}, 16'h0000);
    end
    press(4'b0010, 8);
    chk("fail_to_entry", {12'b0, cur_digit}, 16'h0001);
    press(4'b1000, 8);
`endif

    // Asynchronous reset at digit_idx=2
    press(4'b0010, 8);
    press(4'b0100, 8);
    press(4'b0100, 8);
    press(4'b0010, 8);
    chk("pre_reset_idx2", {14'b0, digit_idx}, 16'h0002);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_userPin", userPin, 16'h0000);
    chk("async_rst_cur", {12'b0, cur_digit}, 16'h0000);
    chk("async_rst_idx", {14'b0, digit_idx}, 16'h0000);
    chk("async_rst_valid", {15'b0, validPin}, 16'h0000);
    chk("async_rst_locked", {15'b0, locked}, 16'h0000);
    repeat (2) tick();
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idx", {14'b0, digit_idx}, 16'h0000);
    enter_pin(16'h4321);
    chk("post_rst_userPin", userPin, 16'h4321);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
